// File: rtl/tff_toggle_scheduler_if.sv
// Requester-side bundle for the shared toggle-flip-flop scheduler:
// per-requester burst requests in, grant/completion/toggle-enable out.
interface tff_toggle_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int NTFF  = 8,
    parameter int CNT_W = 4
);
    localparam int IDX_W = $clog2(NTFF);
    localparam int OWN_W = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*IDX_W-1:0] req_idx;
    logic [NREQ*CNT_W-1:0] req_cnt;
    logic                  abort;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  aborted;
    logic [NTFF-1:0]       t_en;
    logic                  busy;
    logic [OWN_W-1:0]      owner;

    modport master (
        output req, req_idx, req_cnt, abort,
        input  gnt, done, aborted, t_en, busy, owner
    );

    modport slave (
        input  req, req_idx, req_cnt, abort,
        output gnt, done, aborted, t_en, busy, owner
    );
endinterface

// File: rtl/tff_toggle_scheduler.sv
// Round-robin scheduler sharing one bank of toggle flip-flops between requesters;
// each accepted burst drives one T-enable per clock, then pulses done.
module tff_toggle_scheduler #(
    parameter int NREQ  = 4,
    parameter int NTFF  = 8,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tff_toggle_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(NTFF);
    localparam int OWN_W = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t           state_q, state_n;
    logic [OWN_W-1:0] ptr_q, ptr_n;
    logic [OWN_W-1:0] owner_q, owner_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [CNT_W-1:0] rem_q, rem_n;
    logic [NREQ-1:0]  gnt_q, gnt_n;
    logic [NREQ-1:0]  done_q, done_n;
    logic             aborted_q, aborted_n;
    logic [NTFF-1:0]  t_en_q, t_en_n;
    logic             busy_q, busy_n;

    logic [IDX_W-1:0] idx_arr [NREQ];
    logic [CNT_W-1:0] cnt_arr [NREQ];
    logic             win_found;
    logic [OWN_W-1:0] win_idx;
    logic [OWN_W-1:0] cand_idx;
    int unsigned      cand;

    for (genvar g = 0; g < NREQ; g++) begin : g_split
        assign idx_arr[g] = bus.req_idx[g*IDX_W +: IDX_W];
        assign cnt_arr[g] = bus.req_cnt[g*CNT_W +: CNT_W];
    end

    // First requesting index at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = cand[OWN_W-1:0];
            if (!win_found && bus.req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_n   = state_q;
        ptr_n     = ptr_q;
        owner_n   = owner_q;
        idx_n     = idx_q;
        rem_n     = rem_q;
        gnt_n     = '0;
        done_n    = '0;
        aborted_n = 1'b0;
        t_en_n    = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    owner_n        = win_idx;
                    idx_n          = idx_arr[win_idx];
                    gnt_n[win_idx] = 1'b1;
                    state_n        = ISSUE;
                    // A zero-length burst spends its gnt cycle in ISSUE with t_en
                    // held low, so done lands exactly one cycle after gnt.
                    if (cnt_arr[win_idx] != '0) begin
                        t_en_n[idx_arr[win_idx]] = 1'b1;
                        rem_n = cnt_arr[win_idx] - 1'b1;
                    end else begin
                        rem_n = '0;
                    end
                end
            end
            ISSUE: begin
                if (t_en_q == '0 || rem_q == '0) begin
                    state_n         = DONE;
                    done_n[owner_q] = 1'b1;
                end else if (bus.abort) begin
                    state_n         = DONE;
                    done_n[owner_q] = 1'b1;
                    aborted_n       = 1'b1;
                end else begin
                    t_en_n[idx_q] = 1'b1;
                    rem_n         = rem_q - 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                ptr_n   = (owner_q == OWN_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            idx_q     <= '0;
            rem_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            aborted_q <= 1'b0;
            t_en_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            ptr_q     <= ptr_n;
            owner_q   <= owner_n;
            idx_q     <= idx_n;
            rem_q     <= rem_n;
            gnt_q     <= gnt_n;
            done_q    <= done_n;
            aborted_q <= aborted_n;
            t_en_q    <= t_en_n;
            busy_q    <= busy_n;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.aborted = aborted_q;
    assign bus.t_en    = t_en_q;
    assign bus.busy    = busy_q;
    assign bus.owner   = owner_q;
endmodule
